// File: rtl/parallax_scroll_ctrl_if.sv
// Control and offset bus between the UI/sync side and the parallax scroll scheduler.
// The master drives the sync and controls; the slave (the scheduler) returns the committed offsets and status.
interface parallax_scroll_ctrl_if;
    logic        vsync;
    logic        pause;
    logic        reverse;
    logic [1:0]  speed;
    logic [49:0] off_x;
    logic [49:0] off_y;
    logic [9:0]  frame;
    logic        busy;
    logic        commit;

    modport master (
        output vsync, pause, reverse, speed,
        input  off_x, off_y, frame, busy, commit
    );

    modport slave (
        input  vsync, pause, reverse, speed,
        output off_x, off_y, frame, busy, commit
    );
endinterface

// File: rtl/parallax_scroll_ctrl.sv
// Per-frame scroll scheduler: ten Q10.2 accumulators stepped through one shared adder, then committed atomically.
// Latency 11 cycles from the vsync edge to the offset update; one extra edge may be queued while busy.
module parallax_scroll_ctrl #(
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [39:0] VEL_X = {8'd2, 8'd8, 8'd16, 8'd28, 8'd64},
    parameter logic [39:0] VEL_Y = {8'd1, 8'd1, 8'd2, 8'd6, 8'd8}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parallax_scroll_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_COMMIT} state_e;

    typedef struct packed {
        logic       pause;
        logic       reverse;
        logic [1:0] speed;
    } cfg_t;

    typedef struct packed {
        logic       reverse;
        logic [1:0] speed;
    } step_cfg_t;

    localparam logic        ACTIVE_LVL = !VSYNC_ACTIVE_LOW;
    localparam logic [79:0] VEL_ALL    = {VEL_Y, VEL_X};

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    step_cfg_t         cfg_q, cfg_d;
    cfg_t              pend_cfg_q, pend_cfg_d;
    logic              pending_q, pending_d;
    logic              vsync_dly_q, vsync_dly_d;
    logic [9:0]        frame_q, frame_d;
    logic [9:0][11:0]  acc_q, acc_d;
    logic [49:0]       off_x_q, off_x_d;
    logic [49:0]       off_y_q, off_y_d;
    logic              commit_q, commit_d;

    cfg_t        bus_cfg, start_cfg;
    logic        start;
    logic        edge_det;
    logic [7:0]  vel_sel;
    logic [11:0] step;
    logic [11:0] sum;

    assign bus_cfg  = {bus.pause, bus.reverse, bus.speed};
    assign edge_det = (bus.vsync == ACTIVE_LVL) && (bus.vsync != vsync_dly_q);

    // The single shared adder/subtractor; idx selects X layers 0..4 then Y layers 0..4.
    assign vel_sel = VEL_ALL[{idx_q, 3'b000} +: 8];
    assign step    = {4'd0, vel_sel} << cfg_q.speed;
    assign sum     = cfg_q.reverse ? (acc_q[idx_q] - step) : (acc_q[idx_q] + step);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cfg_d       = cfg_q;
        pend_cfg_d  = pend_cfg_q;
        pending_d   = pending_q;
        vsync_dly_d = bus.vsync;
        frame_d     = frame_q;
        acc_d       = acc_q;
        off_x_d     = off_x_q;
        off_y_d     = off_y_q;
        commit_d    = 1'b0;
        start       = 1'b0;
        start_cfg   = bus_cfg;

        if (edge_det) begin
            frame_d = frame_q + 10'd1;
        end

        case (state_q)
            ST_IDLE: begin
                start = edge_det;
            end
            ST_UPDATE: begin
                acc_d[idx_q] = sum;
                if (idx_q == 4'd9) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                // The running frame keeps its own controls; a queued edge parks its controls aside.
                if (edge_det && !pending_q) begin
                    pending_d  = 1'b1;
                    pend_cfg_d = bus_cfg;
                end
            end
            ST_COMMIT: begin
                for (int k = 0; k < 5; k++) begin
                    off_x_d[k*10 +: 10] = acc_q[k][11:2];
                    off_y_d[k*10 +: 10] = acc_q[k+5][11:2];
                end
                commit_d  = 1'b1;
                state_d   = ST_IDLE;
                pending_d = 1'b0;
                if (pending_q) begin
                    start     = 1'b1;
                    start_cfg = pend_cfg_q;
                end else begin
                    start = edge_det;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            cfg_d   = '{reverse: start_cfg.reverse, speed: start_cfg.speed};
            idx_d   = 4'd0;
            state_d = start_cfg.pause ? ST_IDLE : ST_UPDATE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            cfg_q       <= '0;
            pend_cfg_q  <= '0;
            pending_q   <= 1'b0;
            vsync_dly_q <= !ACTIVE_LVL;
            frame_q     <= 10'd0;
            acc_q       <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cfg_q       <= cfg_d;
            pend_cfg_q  <= pend_cfg_d;
            pending_q   <= pending_d;
            vsync_dly_q <= vsync_dly_d;
            frame_q     <= frame_d;
            acc_q       <= acc_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            commit_q    <= commit_d;
        end
    end

    assign bus.off_x  = off_x_q;
    assign bus.off_y  = off_y_q;
    assign bus.frame  = frame_q;
    assign bus.commit = commit_q;
    assign bus.busy   = (state_q != ST_IDLE) || commit_q;
endmodule

// File: tb/tb_parallax_scroll_ctrl.sv
// Bench for parallax_scroll_ctrl: directed scenarios plus randomized frames against a whole-frame reference model.
module tb_parallax_scroll_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    // Model state: integer accumulators in quarter pixels, X layers 0..4 then Y layers 0..4.
    int acc_m [10];
    int frame_m;
    int vel_m [10] = '{64, 28, 16, 8, 2, 8, 6, 2, 1, 1};

    parallax_scroll_ctrl_if bus_if ();

    parallax_scroll_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 10; k++) acc_m[k] = 0;
        frame_m = 0;
    endtask

    task automatic model_frame(input bit p, input bit r, input int s);
        frame_m = (frame_m + 1) % 1024;
        if (!p) begin
            for (int k = 0; k < 10; k++) begin
                int d;
                d = vel_m[k] * (1 << s);
                acc_m[k] = ((r ? acc_m[k] - d : acc_m[k] + d) % 4096 + 4096) % 4096;
            end
        end
    endtask

    function automatic logic [49:0] exp_off(input int base);
        logic [49:0] v;
        v = '0;
        for (int k = 0; k < 5; k++) v[k*10 +: 10] = 10'(acc_m[base+k] / 4);
        return v;
    endfunction

    task automatic send_edge();
        bus_if.vsync = 1'b1;
        tick();
        bus_if.vsync = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus_if.vsync = 1'b1;
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic monitor(output int nbusy, output int ncommit,
                           output logic [49:0] fx, output logic [49:0] fy);
        nbusy   = 0;
        ncommit = 0;
        fx      = '0;
        fy      = '0;
        while (bus_if.busy && nbusy < 100) begin
            nbusy++;
            if (bus_if.commit) begin
                ncommit++;
                if (ncommit == 1) begin
                    fx = bus_if.off_x;
                    fy = bus_if.off_y;
                end
            end
            tick();
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " off_x"}, bus_if.off_x, exp_off(0));
        chk({tag, " off_y"}, bus_if.off_y, exp_off(5));
        chk({tag, " frame"}, bus_if.frame, frame_m);
    endtask

    task automatic run_frame(input bit p, input bit r, input logic [1:0] s, input string tag);
        int nb, nc;
        logic [49:0] fx, fy;
        bus_if.pause   = p;
        bus_if.reverse = r;
        bus_if.speed   = s;
        send_edge();
        model_frame(p, r, int'(s));
        // Controls after the edge must not influence this frame.
        bus_if.pause   = 1'($urandom);
        bus_if.reverse = 1'($urandom);
        bus_if.speed   = 2'($urandom);
        if (!p) begin
            monitor(nb, nc, fx, fy);
            chk({tag, " busy cycles"}, nb, 12);
            chk({tag, " commits"}, nc, 1);
        end else begin
            nb = 0;
            nc = 0;
            repeat (4) begin
                if (bus_if.busy) nb++;
                if (bus_if.commit) nc++;
                tick();
            end
            chk({tag, " paused busy"}, nb, 0);
            chk({tag, " paused commits"}, nc, 0);
        end
        check_state(tag);
    endtask

    initial begin
        int nb, nc;
        logic [49:0] fx, fy, efx, efy;

        rst_n          = 1'b0;
        bus_if.vsync   = 1'b1;
        bus_if.pause   = 1'b0;
        bus_if.reverse = 1'b0;
        bus_if.speed   = 2'd0;
        tick();
        tick();
        model_reset();
        chk("reset off_x", bus_if.off_x, 50'd0);
        chk("reset off_y", bus_if.off_y, 50'd0);
        chk("reset frame", bus_if.frame, 10'd0);
        chk("reset busy", bus_if.busy, 1'b0);
        chk("reset commit", bus_if.commit, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single default frame.
        run_frame(1'b0, 1'b0, 2'd0, "s1");
        chk("s1 off_x const", bus_if.off_x, {10'd0, 10'd2, 10'd4, 10'd7, 10'd16});
        chk("s1 off_y const", bus_if.off_y, {10'd0, 10'd0, 10'd0, 10'd1, 10'd2});
        chk("s1 frame const", bus_if.frame, 10'd1);

        // 64 frames: layer 0 X wraps back to zero.
        do_reset();
        for (int i = 0; i < 64; i++) run_frame(1'b0, 1'b0, 2'd0, "s2");
        chk("s2 layer0 x", bus_if.off_x[9:0], 10'd0);
        chk("s2 layer4 x", bus_if.off_x[49:40], 10'd32);
        chk("s2 frame", bus_if.frame, 10'd64);

        // Reverse and speed.
        do_reset();
        run_frame(1'b0, 1'b1, 2'd0, "s3 rev");
        chk("s3 rev layer0 x", bus_if.off_x[9:0], 10'd1008);
        chk("s3 rev layer1 x", bus_if.off_x[19:10], 10'd1017);
        do_reset();
        run_frame(1'b0, 1'b0, 2'd3, "s3 spd");
        chk("s3 spd layer0 x", bus_if.off_x[9:0], 10'd128);

        // Paused edges, then pause toggled mid-sequence.
        for (int i = 0; i < 5; i++) run_frame(1'b1, 1'b0, 2'd0, "s4 pause");
        chk("s4 frame", bus_if.frame, 10'd6);
        bus_if.pause   = 1'b0;
        bus_if.reverse = 1'b0;
        bus_if.speed   = 2'd0;
        send_edge();
        model_frame(1'b0, 1'b0, 0);
        repeat (4) tick();
        bus_if.pause = 1'b1;
        monitor(nb, nc, fx, fy);
        chk("s4 toggle busy", nb, 8);
        chk("s4 toggle commits", nc, 1);
        check_state("s4 toggle");

        // Queued edge at T4 with x2 speed, dropped edge at T6.
        do_reset();
        bus_if.pause   = 1'b0;
        bus_if.reverse = 1'b0;
        bus_if.speed   = 2'd0;
        send_edge();
        model_frame(1'b0, 1'b0, 0);
        efx = exp_off(0);
        efy = exp_off(5);
        model_frame(1'b0, 1'b0, 1);
        frame_m++;
        bus_if.vsync = 1'b1;
        tick();
        tick();
        tick();
        bus_if.vsync = 1'b0;
        bus_if.speed = 2'd1;
        tick();
        bus_if.vsync   = 1'b1;
        bus_if.speed   = 2'd3;
        bus_if.reverse = 1'b1;
        tick();
        bus_if.vsync = 1'b0;
        tick();
        bus_if.reverse = 1'b0;
        bus_if.speed   = 2'd0;
        monitor(nb, nc, fx, fy);
        chk("s5 busy cycles", nb, 17);
        chk("s5 commits", nc, 2);
        chk("s5 first off_x", fx, efx);
        chk("s5 first off_y", fy, efy);
        check_state("s5 second");
        chk("s5 frame const", bus_if.frame, 10'd3);

        // Reset in the middle of a sequence.
        send_edge();
        repeat (5) tick();
        rst_n        = 1'b0;
        bus_if.vsync = 1'b1;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk("s6 off_x", bus_if.off_x, 50'd0);
        chk("s6 off_y", bus_if.off_y, 50'd0);
        chk("s6 frame", bus_if.frame, 10'd0);
        chk("s6 busy", bus_if.busy, 1'b0);
        nb = 0;
        nc = 0;
        repeat (14) begin
            if (bus_if.busy) nb++;
            if (bus_if.commit) nc++;
            tick();
        end
        chk("s6 quiet busy", nb, 0);
        chk("s6 quiet commits", nc, 0);
        run_frame(1'b0, 1'b0, 2'd0, "s6 rerun");
        chk("s6 rerun off_x const", bus_if.off_x, {10'd0, 10'd2, 10'd4, 10'd7, 10'd16});

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            run_frame($urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
